// File: rtl/decimal_entry.sv
// rtl/decimal_entry.sv - pushbutton decimal entry with debounced keys and valid/ack result handshake
// Digits accumulate in BCD order into a 24-bit binary value; enter signs it and holds it until acked.

module decimal_entry_key #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_prev_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         level_q      <= 1'b1;
         level_prev_q <= 1'b1;
         cnt_q        <= '0;
         press        <= 1'b0;
      end else begin
         sync1_q      <= key_n;
         sync2_q      <= sync1_q;
         level_prev_q <= level_q;
         press        <= level_prev_q & ~level_q;
         // Level flips on the edge where the mismatch count reaches DEBOUNCE_CYCLES.
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_q   <= '0;
            level_q <= sync2_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
endmodule

module decimal_entry #(
   parameter int DIGITS          = 7,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  digit_in,
   input  logic        sign_in,
   input  logic        key_digit_n,
   input  logic        key_enter_n,
   input  logic        clear,
   input  logic        value_ack,
   output logic [31:0] value_out,
   output logic        value_valid,
   output logic [2:0]  digit_count,
   output logic        entry_error
);
   localparam logic [2:0] MAX_COUNT = 3'(DIGITS);

   typedef enum logic {ENTRY, HOLD} state_t;

   state_t      state_q, state_d;
   logic [23:0] acc_q, acc_d;
   logic [2:0]  count_d;
   logic        err_d, valid_d;
   logic [31:0] value_d;
   logic        digit_p, enter_p;

   decimal_entry_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_digit (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_digit_n),
      .press (digit_p)
   );

   decimal_entry_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_enter (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_enter_n),
      .press (enter_p)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ENTRY;
         acc_q       <= '0;
         digit_count <= '0;
         entry_error <= 1'b0;
         value_valid <= 1'b0;
         value_out   <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         digit_count <= count_d;
         entry_error <= err_d;
         value_valid <= valid_d;
         value_out   <= value_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = digit_count;
      err_d   = entry_error;
      valid_d = value_valid;
      value_d = value_out;
      if (clear) begin
         state_d = ENTRY;
         acc_d   = '0;
         count_d = '0;
         err_d   = 1'b0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            ENTRY: begin
               // Enter takes priority; a coincident digit press is dropped.
               if (enter_p) begin
                  value_d = sign_in ? (32'd0 - {8'd0, acc_q}) : {8'd0, acc_q};
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else if (digit_p) begin
                  if (digit_in <= 4'd9 && digit_count < MAX_COUNT) begin
                     acc_d   = (acc_q << 3) + (acc_q << 1) + {20'd0, digit_in};
                     count_d = digit_count + 3'd1;
                     err_d   = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (value_ack) begin
                  valid_d = 1'b0;
                  acc_d   = '0;
                  count_d = '0;
                  err_d   = 1'b0;
                  state_d = ENTRY;
               end
            end
            default: state_d = ENTRY;
         endcase
      end
   end
endmodule
